// File: rtl/rotation_cordic_iter.sv
// ---------------------------------------------------------------------------
// rotation_cordic_iter
//
// Iterative rotation-mode CORDIC. Rotates (x, y) by angle z using one shared
// micro-rotation datapath that runs once per enabled cycle. The result
// carries the CORDIC gain K (about 1.6468); with x = A/K and y = 0 the
// outputs are A*cos(z) and A*sin(z). Angle full scale: 2^(Z_WIDTH-1) = pi.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   en         clock enable; when low all state freezes, no handshake completes
//   valid_in   input word valid
//   ready_in   block can accept an input (en && IDLE)
//   x_in/y_in  signed input vector
//   z_in       signed rotation angle
//   valid_out  result valid (DONE state, not gated by en)
//   ready_out  downstream accepts the result
//   x_out/y_out rotated vector, gain included
//   z_out      residual angle
// ---------------------------------------------------------------------------
module rotation_cordic_iter #(
    parameter int ITERATIONS = 15,
    parameter int XY_WIDTH   = 16,
    parameter int Z_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic signed [XY_WIDTH-1:0] x_in,
    input  logic signed [XY_WIDTH-1:0] y_in,
    input  logic signed [Z_WIDTH-1:0]  z_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic signed [XY_WIDTH-1:0] x_out,
    output logic signed [XY_WIDTH-1:0] y_out,
    output logic signed [Z_WIDTH-1:0]  z_out
);

    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // alpha_i = trunc(atan(2^-i) / pi * 2^(Z_WIDTH-1)). pi is derived from
    // the same atan so that alpha_0 lands exactly on pi/4.
    function automatic logic [Z_WIDTH-1:0] atan_angle(input int i);
        real pi_r;
        real ang;
        int  v;
        pi_r = 4.0 * $atan(1.0);
        ang  = $atan(1.0 / (2.0 ** i)) / pi_r * (2.0 ** (Z_WIDTH - 1));
        v    = $rtoi(ang);
        return v[Z_WIDTH-1:0];
    endfunction

    logic [Z_WIDTH-1:0] alpha [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_alpha
        assign alpha[g] = atan_angle(g);
    end

    state_t                     state_q, state_d;
    logic signed [XY_WIDTH-1:0] x_q, x_d;
    logic signed [XY_WIDTH-1:0] y_q, y_d;
    logic signed [Z_WIDTH-1:0]  z_q, z_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic signed [XY_WIDTH-1:0] x_shift;
    logic signed [XY_WIDTH-1:0] y_shift;
    logic                       z_neg;
    logic                       far_quadrant;

    assign ready_in  = en && (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        cnt_d        = cnt_q;
        x_shift      = x_q >>> cnt_q;
        y_shift      = y_q >>> cnt_q;
        z_neg        = z_q[Z_WIDTH-1];
        // |z| > pi/2 when the two top angle bits differ.
        far_quadrant = z_in[Z_WIDTH-1] != z_in[Z_WIDTH-2];

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = ROTATE;
                    cnt_d   = '0;
                    if (far_quadrant) begin
                        // Rotate by pi up front: negate vector, subtract pi
                        // from the angle by flipping its MSB.
                        x_d = -x_in;
                        y_d = -y_in;
                        z_d = {~z_in[Z_WIDTH-1], z_in[Z_WIDTH-2:0]};
                    end else begin
                        x_d = x_in;
                        y_d = y_in;
                        z_d = z_in;
                    end
                end
            end
            ROTATE: begin
                if (z_neg) begin
                    x_d = x_q + y_shift;
                    y_d = y_q - x_shift;
                    z_d = z_q + alpha[cnt_q];
                end else begin
                    x_d = x_q - y_shift;
                    y_d = y_q + x_shift;
                    z_d = z_q - alpha[cnt_q];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The combinational block already assumes the capture happens only when
    // ready_in is high; gating the register update with en makes that hold.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
